// File: rtl/cronometer_display.sv
// ---------------------------------------------------------------------------------------------
// cronometer_display
//   Display/alarm back-end for the countdown cronometer. The BCD digits are sampled on each
//   1 ms tick and shown on four active-low 7-segment outputs as M.SS.d (hex3..hex0). A 4-state
//   FSM selects the display mode:
//     RUN  : steady digits
//     WARN : fast blink, entered when less than WARN_SECONDS seconds remain
//     WON  : frozen digits
//     OVER : blinking 0.00.0 with the alarm LED toggling
//
// Parameters
//   BLINK_MS      half-period of the OVER blink and alarm LED toggle, in tick_1ms pulses
//   WARN_BLINK_MS half-period of the WARN blink, in tick_1ms pulses
//   WARN_SECONDS  WARN threshold in seconds; the minute digit must also be zero (1..59)
//
// Ports
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   tick_1ms       in   one-clock pulse every millisecond
//   min_unidade    in   BCD minutes
//   seg_dezena     in   BCD seconds tens
//   seg_unidade    in   BCD seconds units
//   ms_decimos     in   BCD tenths of a second
//   time_over      in   countdown expired (level)
//   game_won       in   game won (level or pulse)
//   hex3..hex0     out  active-low segments {g,f,e,d,c,b,a}
//   led_alarm      out  alarm LED, active-high
//   display_state  out  00 RUN, 01 WARN, 10 WON, 11 OVER
//
// Build option
//   DISPLAY_LZ_BLANK_EN : blank leading zeros (hex3, then hex2) while in RUN/WARN.
// ---------------------------------------------------------------------------------------------
module cronometer_display #(
  parameter int unsigned BLINK_MS      = 250,
  parameter int unsigned WARN_BLINK_MS = 100,
  parameter int unsigned WARN_SECONDS  = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_1ms,
  input  logic [3:0] min_unidade,
  input  logic [3:0] seg_dezena,
  input  logic [3:0] seg_unidade,
  input  logic [3:0] ms_decimos,
  input  logic       time_over,
  input  logic       game_won,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0,
  output logic       led_alarm,
  output logic [1:0] display_state
);

  localparam int unsigned MaxHalf = (BLINK_MS > WARN_BLINK_MS) ? BLINK_MS : WARN_BLINK_MS;
  localparam int unsigned CntW    = (MaxHalf > 1) ? $clog2(MaxHalf) : 1;

  localparam logic [CntW-1:0] BlinkLast = CntW'(BLINK_MS - 1);
  localparam logic [CntW-1:0] WarnLast  = CntW'(WARN_BLINK_MS - 1);

  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegZero  = 7'h40;

  typedef enum logic [1:0] {
    StRun  = 2'b00,
    StWarn = 2'b01,
    StWon  = 2'b10,
    StOver = 2'b11
  } state_e;

  state_e state_q, state_d;

  logic [3:0] snap_min_q, snap_sd_q, snap_su_q, snap_ms_q;
  logic       snap_en;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic [CntW-1:0] half_last;

  logic [6:0] hex3_q, hex2_q, hex1_q, hex0_q;
  logic [6:0] hex3_d, hex2_d, hex1_d, hex0_d;
  logic       led_q, led_d;

  logic [6:0] seconds;
  logic       digits_valid;
  logic       warn_cond;

  // BCD to active-low 7-segment; non-decimal codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h3F;
    endcase
    return seg;
  endfunction

  // -------------------------------------------------------------------------------------------
  // Digit snapshot: follows the inputs on ticks only while the countdown is live.
  // -------------------------------------------------------------------------------------------
  assign snap_en = tick_1ms && ((state_q == StRun) || (state_q == StWarn));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_min_q <= 4'hF;
      snap_sd_q  <= 4'hF;
      snap_su_q  <= 4'hF;
      snap_ms_q  <= 4'hF;
    end else if (snap_en) begin
      snap_min_q <= min_unidade;
      snap_sd_q  <= seg_dezena;
      snap_su_q  <= seg_unidade;
      snap_ms_q  <= ms_decimos;
    end
  end

  // Remaining-seconds check uses only the snapshot so the FSM sees a coherent time value.
  assign digits_valid = (snap_min_q <= 4'd9) && (snap_sd_q <= 4'd9) &&
                        (snap_su_q <= 4'd9) && (snap_ms_q <= 4'd9);
  assign seconds      = ({3'b000, snap_sd_q} * 7'd10) + {3'b000, snap_su_q};
  assign warn_cond    = digits_valid && (snap_min_q == 4'd0) &&
                        (seconds < 7'(WARN_SECONDS));

  // -------------------------------------------------------------------------------------------
  // Display FSM
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (time_over) begin
      state_d = StOver;
    end else if (((state_q == StRun) || (state_q == StWarn)) && game_won) begin
      state_d = StWon;
    end else if ((state_q == StRun) && warn_cond) begin
      state_d = StWarn;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Blink timebase: restarts visible on every state change.
  // -------------------------------------------------------------------------------------------
  assign half_last = (state_q == StWarn) ? WarnLast : BlinkLast;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (state_d != state_q) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (tick_1ms) begin
      // >= keeps the counter bounded even if it holds a value above the current wrap point.
      if (cnt_q >= half_last) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Output selection (registered below)
  // -------------------------------------------------------------------------------------------
  always_comb begin
    logic [6:0] dig3, dig2, dig1, dig0;
    logic [6:0] run3, run2;

    dig3 = seg_decode(snap_min_q);
    dig2 = seg_decode(snap_sd_q);
    dig1 = seg_decode(snap_su_q);
    dig0 = seg_decode(snap_ms_q);

    run3 = dig3;
    run2 = dig2;
`ifdef DISPLAY_LZ_BLANK_EN
    if (snap_min_q == 4'd0) begin
      run3 = SegBlank;
      if (snap_sd_q == 4'd0) begin
        run2 = SegBlank;
      end
    end
`endif

    hex3_d = SegBlank;
    hex2_d = SegBlank;
    hex1_d = SegBlank;
    hex0_d = SegBlank;
    led_d  = 1'b0;

    unique case (state_q)
      StRun: begin
        hex3_d = run3;
        hex2_d = run2;
        hex1_d = dig1;
        hex0_d = dig0;
      end
      StWarn: begin
        if (phase_q) begin
          hex3_d = run3;
          hex2_d = run2;
          hex1_d = dig1;
          hex0_d = dig0;
        end
      end
      StWon: begin
        hex3_d = dig3;
        hex2_d = dig2;
        hex1_d = dig1;
        hex0_d = dig0;
      end
      StOver: begin
        if (phase_q) begin
          hex3_d = SegZero;
          hex2_d = SegZero;
          hex1_d = SegZero;
          hex0_d = SegZero;
        end
        led_d = phase_q;
      end
      default: begin
        led_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex3_q <= SegBlank;
      hex2_q <= SegBlank;
      hex1_q <= SegBlank;
      hex0_q <= SegBlank;
      led_q  <= 1'b0;
    end else begin
      hex3_q <= hex3_d;
      hex2_q <= hex2_d;
      hex1_q <= hex1_d;
      hex0_q <= hex0_d;
      led_q  <= led_d;
    end
  end

  assign hex3          = hex3_q;
  assign hex2          = hex2_q;
  assign hex1          = hex1_q;
  assign hex0          = hex0_q;
  assign led_alarm     = led_q;
  assign display_state = state_q;

endmodule

// File: tb/tb_cronometer_display.sv
// Bench for cronometer_display: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural model of the display rules.
module tb_cronometer_display;

  localparam int unsigned BlinkMs = 250;
  localparam int unsigned WarnMs  = 100;
  localparam int unsigned WarnSec = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] mu = 4'd0, sd = 4'd0, su = 4'd0, ms = 4'd0;
  logic       to = 1'b0, gw = 1'b0;
  logic [6:0] hex3, hex2, hex1, hex0;
  logic       led;
  logic [1:0] dstate;

  cronometer_display #(
    .BLINK_MS      (BlinkMs),
    .WARN_BLINK_MS (WarnMs),
    .WARN_SECONDS  (WarnSec)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tick_1ms      (tick),
    .min_unidade   (mu),
    .seg_dezena    (sd),
    .seg_unidade   (su),
    .ms_decimos    (ms),
    .time_over     (to),
    .game_won      (gw),
    .hex3          (hex3),
    .hex2          (hex2),
    .hex1          (hex1),
    .hex0          (hex0),
    .led_alarm     (led),
    .display_state (dstate)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ behavioural model
  int         m_state = 0;   // 0 RUN, 1 WARN, 2 WON, 3 OVER
  int         m_ticks = 0;   // ticks seen since entering the current state
  logic [3:0] m_snap[4] = '{default: 4'hF};  // [3]=min [2]=sec tens [1]=sec units [0]=tenths
  logic [6:0] e_hex[4]  = '{default: 7'h7F};
  logic       e_led = 1'b0;
  bit         chk_en = 1'b0;

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] tbl[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00,
                            7'h10};
    if (d > 4'd9) return 7'h3F;
    return tbl[d];
  endfunction

  task automatic model_step();
    int         nxt, secs, half;
    bit         ph, valid;
    logic [6:0] v[4], lz[4];
    if (!reset_n) begin
      m_state = 0;
      m_ticks = 0;
      m_snap  = '{default: 4'hF};
      e_hex   = '{default: 7'h7F};
      e_led   = 1'b0;
    end else begin
      half = (m_state == 1) ? WarnMs : BlinkMs;
      ph   = ((m_ticks / half) % 2) == 0;
      for (int i = 0; i < 4; i++) begin
        v[i]  = seg(m_snap[i]);
        lz[i] = v[i];
      end
`ifdef DISPLAY_LZ_BLANK_EN
      if (m_snap[3] == 0) lz[3] = 7'h7F;
      if (m_snap[3] == 0 && m_snap[2] == 0) lz[2] = 7'h7F;
`endif
      e_led = 1'b0;
      case (m_state)
        0: e_hex = lz;
        1: e_hex = ph ? lz : '{default: 7'h7F};
        2: e_hex = v;
        default: begin
          e_hex = ph ? '{default: 7'h40} : '{default: 7'h7F};
          e_led = ph;
        end
      endcase
      valid = 1'b1;
      for (int i = 0; i < 4; i++) if (m_snap[i] > 9) valid = 1'b0;
      secs = m_snap[2] * 10 + m_snap[1];
      nxt  = m_state;
      if (to) nxt = 3;
      else if (m_state <= 1 && gw) nxt = 2;
      else if (m_state == 0 && valid && m_snap[3] == 0 && secs < WarnSec) nxt = 1;
      if (m_state <= 1 && tick) begin
        m_snap[3] = mu;
        m_snap[2] = sd;
        m_snap[1] = su;
        m_snap[0] = ms;
      end
      if (nxt != m_state) m_ticks = 0;
      else if (tick) m_ticks++;
      m_state = nxt;
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    model_step();
  end

  // Single compare process: every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("cyc_hex3", hex3, e_hex[3]);
      chk("cyc_hex2", hex2, e_hex[2]);
      chk("cyc_hex1", hex1, e_hex[1]);
      chk("cyc_hex0", hex0, e_hex[0]);
      chk("cyc_led", led, e_led);
      chk("cyc_state", dstate, m_state[1:0]);
    end
  end

  // ------------------------------------------------------------------ stimulus helpers
  // Drive inputs for one clock; returns just after the next falling edge.
  task automatic drive(input logic t, input logic o, input logic g,
                       input logic [3:0] m, input logic [3:0] d, input logic [3:0] u,
                       input logic [3:0] s);
    tick = t; to = o; gw = g; mu = m; sd = d; su = u; ms = s;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
  endtask

  task automatic lit_hex(input string name, input logic [6:0] h3, input logic [6:0] h2,
                         input logic [6:0] h1, input logic [6:0] h0);
    chk({name, "_hex3"}, hex3, h3);
    chk({name, "_hex2"}, hex2, h2);
    chk({name, "_hex1"}, hex1, h1);
    chk({name, "_hex0"}, hex0, h0);
  endtask

  function automatic logic [3:0] rnd_digit(input int unsigned hi);
    if ($urandom_range(0, 39) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, hi));
  endfunction

  initial begin
    #1;
    reset_n = 1'b0;
    chk_en  = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_hex0", hex0, 7'h7F);
    chk("rst_led", led, 1'b0);
    reset_n = 1'b1;

    // Reset with no tick: dashes after one edge.
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    lit_hex("dash", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    chk("dash_state", dstate, 2'b00);
    chk("dash_led", led, 1'b0);

    // 2:59.9 shown on the second edge after the tick.
    drive(1, 0, 0, 2, 5, 9, 9);
    drive(0, 0, 0, 2, 5, 9, 9);
    lit_hex("t259", 7'h24, 7'h12, 7'h10, 7'h10);
    chk("t259_state", dstate, 2'b00);

    // 0:09.5 -> WARN, blinks with 100-tick half-period.
    drive(1, 0, 0, 0, 0, 9, 5);
    drive(0, 0, 0, 0, 0, 9, 5);
    chk("warn_state", dstate, 2'b01);
    chk("warn_vis_hex1", hex1, 7'h10);
    chk("warn_vis_hex0", hex0, 7'h12);
    for (int i = 0; i < 100; i++) drive(1, 0, 0, 0, 0, 9, 5);
    drive(0, 0, 0, 0, 0, 9, 5);
    lit_hex("warn_off", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    for (int i = 0; i < 100; i++) drive(1, 0, 0, 0, 0, 9, 5);
    drive(0, 0, 0, 0, 0, 9, 5);
    chk("warn_on_hex1", hex1, 7'h10);
    chk("warn_on_hex0", hex0, 7'h12);
    chk("warn_hold", dstate, 2'b01);

    // time_over wins over game_won; OVER blink with 250-tick half-period.
    do_reset();
    drive(1, 1, 1, 1, 2, 3, 4);
    chk("over_state", dstate, 2'b11);
    drive(0, 1, 0, 1, 2, 3, 4);
    lit_hex("over_on", 7'h40, 7'h40, 7'h40, 7'h40);
    chk("over_led_on", led, 1'b1);
    for (int i = 0; i < 249; i++) drive(1, 1, 0, 1, 2, 3, 4);
    drive(0, 1, 0, 1, 2, 3, 4);
    chk("over_led_249", led, 1'b1);
    chk("over_hex0_249", hex0, 7'h40);
    drive(1, 1, 0, 1, 2, 3, 4);
    drive(0, 1, 0, 1, 2, 3, 4);
    lit_hex("over_off", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    chk("over_led_off", led, 1'b0);

    // WON freezes 1:23.4.
    do_reset();
    drive(1, 0, 0, 1, 2, 3, 4);
    drive(0, 0, 1, 1, 2, 3, 4);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 9, 8, 7, 6);
    drive(0, 0, 0, 9, 8, 7, 6);
    lit_hex("won", 7'h79, 7'h24, 7'h30, 7'h19);
    chk("won_state", dstate, 2'b10);

`ifdef DISPLAY_LZ_BLANK_EN
    do_reset();
    drive(1, 0, 0, 0, 0, 7, 3);
    drive(0, 0, 0, 0, 0, 7, 3);
    lit_hex("lz", 7'h7F, 7'h7F, 7'h78, 7'h30);
`endif

    // Randomized traffic, model-checked every cycle.
    for (int r = 0; r < 8; r++) begin
      int unsigned dens;
      logic        lvl_to;
      dens   = (r % 2 == 0) ? 100 : $urandom_range(5, 90);
      lvl_to = 1'b0;
      do_reset();
      for (int c = 0; c < 2000; c++) begin
        logic [3:0] rm;
        if ($urandom_range(0, 1499) == 0) lvl_to = 1'b1;
        rm = ($urandom_range(0, 2) == 0) ? 4'd0 : rnd_digit(9);
        if ($urandom_range(0, 1999) == 0) begin
          reset_n = 1'b0;
          lvl_to  = 1'b0;
        end else begin
          reset_n = 1'b1;
        end
        drive(($urandom_range(1, 100) <= dens), lvl_to, ($urandom_range(0, 1199) == 0),
              rm, rnd_digit(5), rnd_digit(9), rnd_digit(9));
      end
      reset_n = 1'b1;
    end

    drive(0, 0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
